// File: rtl/ysyx_25040105_ifu.sv
// Instruction fetch unit: holds the PC, issues one word read at a time and
// hands each fetched word with its PC to decode over a valid/ready handshake.
module ysyx_25040105_ifu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err,
    output logic [31:0]     fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_drop;
    logic [31:0]     r_inst;
    logic            r_inst_err;
    logic [31:0]     r_fetch_cnt;

    state_t          w_state_next;
    logic [XLEN-1:0] w_pc_next;
    logic            w_drop_next;
    logic [31:0]     w_inst_next;
    logic            w_inst_err_next;
    logic [31:0]     w_fetch_cnt_next;
    logic [XLEN-1:0] w_redirect_tgt;

    assign w_redirect_tgt = redirect_pc & ~XLEN'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_inst      <= 32'd0;
            r_inst_err  <= 1'b0;
            r_fetch_cnt <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_drop      <= w_drop_next;
            r_inst      <= w_inst_next;
            r_inst_err  <= w_inst_err_next;
            r_fetch_cnt <= w_fetch_cnt_next;
        end
    end

    // Redirect always wins over sequential pc+4; a response that belongs to
    // the pre-redirect stream is discarded via r_drop.
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_drop_next      = r_drop;
        w_inst_next      = r_inst;
        w_inst_err_next  = r_inst_err;
        w_fetch_cnt_next = r_fetch_cnt;
        case (r_state)
            S_REQ: begin
                if (redirect_valid) begin
                    w_pc_next = w_redirect_tgt;
                end
                if (imem_req_ready) begin
                    w_state_next = S_WAIT;
                    w_drop_next  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    w_drop_next = 1'b0;
                    if (r_drop || redirect_valid) begin
                        w_state_next = S_REQ;
                    end else begin
                        w_inst_next     = imem_resp_data[31:0];
                        w_inst_err_next = imem_resp_err;
                        w_state_next    = S_OUT;
                    end
                    if (redirect_valid) begin
                        w_pc_next = w_redirect_tgt;
                    end
                end else if (redirect_valid) begin
                    w_drop_next = 1'b1;
                    w_pc_next   = w_redirect_tgt;
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    w_fetch_cnt_next = r_fetch_cnt + 32'd1;
                    w_state_next     = S_REQ;
                    w_pc_next        = redirect_valid ? w_redirect_tgt : r_pc + XLEN'(4);
                end else if (redirect_valid) begin
                    w_state_next = S_REQ;
                    w_pc_next    = w_redirect_tgt;
                end
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase
    end

    assign imem_req_valid = (r_state == S_REQ) && !rst;
    assign inst_valid     = (r_state == S_OUT) && !rst;
    assign imem_req_addr  = r_pc & ~XLEN'(3);
    assign inst           = r_inst;
    assign inst_pc        = r_pc;
    assign inst_err       = r_inst_err;
    assign fetch_cnt      = r_fetch_cnt;

endmodule

// File: tb/tb_ysyx_25040105_ifu.sv
// Directed bench for the fetch unit: a small memory model answers each
// request with data equal to its address after a programmable delay.
module tb_ysyx_25040105_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        imem_resp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic [31:0] fetch_cnt;

    int          n_cmp = 0;
    int          n_err = 0;

    // memory model controls
    int          mem_delay = 1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'd0;

    ysyx_25040105_ifu #(
        .XLEN     (32),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_err        (inst_err),
        .fetch_cnt       (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Runs just after each falling edge so it sees the inputs the stimulus
    // process set on that edge; a request seen here is accepted at the next rise.
    always @(negedge clk) begin
        #1;
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt == 0) begin
                    pend            = 1'b0;
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = pend_addr;
                    imem_resp_err   = (pend_addr == err_addr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                pend      = 1'b1;
                pend_addr = imem_req_addr;
                pend_cnt  = mem_delay;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_inst(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                found = 1'b1;
                break;
            end
        end
        check_val({tag, "_arrive"}, 32'(found), 32'd1);
    endtask

    initial begin
        // reset
        rst = 1'b1;
        tick(); tick(); tick();
        check_val("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_val("rst_fetch_cnt", fetch_cnt, 32'd0);
        check_val("rst_pc", inst_pc, 32'h8000_0000);
        rst = 1'b0;

        // 1: free run
        wait_inst("t1_i0");
        check_val("t1_pc0", inst_pc, 32'h8000_0000);
        check_val("t1_inst0", inst, 32'h8000_0000);
        check_val("t1_err0", 32'(inst_err), 32'd0);
        wait_inst("t1_i1");
        check_val("t1_pc1", inst_pc, 32'h8000_0004);
        check_val("t1_inst1", inst, 32'h8000_0004);
        wait_inst("t1_i2");
        check_val("t1_pc2", inst_pc, 32'h8000_0008);
        check_val("t1_inst2", inst, 32'h8000_0008);
        tick();
        check_val("t1_cnt", fetch_cnt, 32'd3);
        check_val("t1_next_addr", imem_req_addr, 32'h8000_000C);

        // 2: decode backpressure
        inst_ready = 1'b0;
        wait_inst("t2_i");
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("t2_hold_valid%0d", i), 32'(inst_valid), 32'd1);
            check_val($sformatf("t2_hold_pc%0d", i), inst_pc, 32'h8000_000C);
            check_val($sformatf("t2_hold_inst%0d", i), inst, 32'h8000_000C);
            check_val($sformatf("t2_no_req%0d", i), 32'(imem_req_valid), 32'd0);
            check_val($sformatf("t2_cnt%0d", i), fetch_cnt, 32'd3);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        check_val("t2_cnt_release", fetch_cnt, 32'd4);
        check_val("t2_valid_release", 32'(inst_valid), 32'd0);

        // 5: access fault on 8000_0010, clean word after it
        err_addr = 32'h8000_0010;
        wait_inst("t5_i0");
        check_val("t5_pc0", inst_pc, 32'h8000_0010);
        check_val("t5_err0", 32'(inst_err), 32'd1);
        wait_inst("t5_i1");
        check_val("t5_pc1", inst_pc, 32'h8000_0014);
        check_val("t5_err1", 32'(inst_err), 32'd0);

        // 3: redirect while waiting on a slow response
        mem_delay = 3;
        tick();                       // REQ for 8000_0018
        tick();                       // WAIT
        check_val("t3_in_wait", 32'(imem_req_valid | inst_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        begin
            logic seen_req;
            seen_req = 1'b0;
            for (int i = 0; i < 10; i++) begin
                check_val($sformatf("t3_drop_valid%0d", i), 32'(inst_valid), 32'd0);
                if (imem_req_valid) begin
                    seen_req = 1'b1;
                    break;
                end
                tick();
            end
            check_val("t3_req_seen", 32'(seen_req), 32'd1);
        end
        check_val("t3_req_addr", imem_req_addr, 32'h8000_0100);
        mem_delay = 1;
        wait_inst("t3_i");
        check_val("t3_pc", inst_pc, 32'h8000_0100);
        check_val("t3_inst", inst, 32'h8000_0100);
        check_val("t3_cnt", fetch_cnt, 32'd6);

        // 4: redirect to unaligned target together with inst_ready
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0202;
        tick();
        redirect_valid = 1'b0;
        check_val("t4_cnt", fetch_cnt, 32'd7);
        check_val("t4_req_valid", 32'(imem_req_valid), 32'd1);
        check_val("t4_req_addr", imem_req_addr, 32'h8000_0200);
        check_val("t4_pc", inst_pc, 32'h8000_0200);
        wait_inst("t4_i");
        check_val("t4_inst_pc", inst_pc, 32'h8000_0200);
        tick();
        check_val("t4_cnt2", fetch_cnt, 32'd8);

        // redirect in OUT without inst_ready drops the held word
        inst_ready = 1'b0;
        wait_inst("t4b_i");
        check_val("t4b_pc", inst_pc, 32'h8000_0204);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        check_val("t4b_cnt", fetch_cnt, 32'd8);
        check_val("t4b_valid", 32'(inst_valid), 32'd0);
        check_val("t4b_req_addr", imem_req_addr, 32'h8000_0300);

        // 6: reset while in WAIT
        tick();
        check_val("t6_in_wait", 32'(imem_req_valid | inst_valid), 32'd0);
        rst = 1'b1;
        tick();
        check_val("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
        check_val("t6_cnt", fetch_cnt, 32'd0);
        rst = 1'b0;
        #1;
        check_val("t6_req_valid", 32'(imem_req_valid), 32'd1);
        check_val("t6_req_addr", imem_req_addr, 32'h8000_0000);
        tick();
        check_val("t6_wait_no_inst", 32'(inst_valid), 32'd0);
        wait_inst("t6_i");
        check_val("t6_pc", inst_pc, 32'h8000_0000);
        check_val("t6_cnt_after", fetch_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
